// File: rtl/mpt_mem_arbiter.sv
// mpt_mem_arbiter: shares one memory master port among the MPT walker's
// per-level stages. Grants one request per cycle. The winner's lane index is
// queued in order, so each response goes back to the lane that issued it.
// Outstanding reads drain before a flush reports completion.
// Optional feature: define MPT_MEM_ARB_RR_EN for round-robin arbitration.
// When it is undefined, arbitration is fixed priority and the lowest lane wins.

package mpt_mem_arbiter_pkg;
  typedef enum logic [0:0] {
    MPT_FLUSH_NONE = 1'b0,
    MPT_FLUSH_REQ  = 1'b1
  } mptw_flush_ctrl_e;

  typedef enum logic [1:0] {
    MPT_FLUSHED_NONE      = 2'd0,
    MPT_FLUSHED_ONGOING   = 2'd1,
    MPT_FLUSHED_COMPLETED = 2'd2
  } mptw_flush_status_e;
endpackage

module mpt_mem_arbiter
  import mpt_mem_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ                       = 3,
  parameter int unsigned MAX_OUTSTANDING               = 4,
  parameter int unsigned MEMORY_TRANSACTION_DATA_WIDTH = 64,
  parameter int unsigned MEMORY_TRANSACTION_ADDR_WIDTH = 64
) (
  input  logic                                                   clk_i,
  input  logic                                                   rst_ni,
  input  logic [NUM_REQ-1:0]                                     slave_mem_req,
  output logic [NUM_REQ-1:0]                                     slave_mem_gnt,
  output logic [NUM_REQ-1:0]                                     slave_mem_valid,
  input  logic [NUM_REQ*MEMORY_TRANSACTION_ADDR_WIDTH-1:0]       slave_mem_addr,
  input  logic [NUM_REQ*MEMORY_TRANSACTION_DATA_WIDTH-1:0]       slave_mem_wdata,
  input  logic [NUM_REQ-1:0]                                     slave_mem_we,
  input  logic [NUM_REQ*(MEMORY_TRANSACTION_DATA_WIDTH/8)-1:0]   slave_mem_be,
  output logic [MEMORY_TRANSACTION_DATA_WIDTH-1:0]               slave_mem_rdata,
  output logic [NUM_REQ-1:0]                                     slave_mem_error,
  output logic                                                   memory_master_mem_req,
  input  logic                                                   memory_master_mem_gnt,
  input  logic                                                   memory_master_mem_valid,
  output logic [MEMORY_TRANSACTION_ADDR_WIDTH-1:0]               memory_master_mem_addr,
  input  logic [MEMORY_TRANSACTION_DATA_WIDTH-1:0]               memory_master_mem_rdata,
  output logic [MEMORY_TRANSACTION_DATA_WIDTH-1:0]               memory_master_mem_wdata,
  output logic                                                   memory_master_mem_we,
  output logic [MEMORY_TRANSACTION_DATA_WIDTH/8-1:0]             memory_master_mem_be,
  input  logic                                                   memory_master_mem_error,
  input  logic [$bits(mptw_flush_ctrl_e)-1:0]                    stage_ctrl_flush,
  output logic [$bits(mptw_flush_status_e)-1:0]                  stage_status_flushed,
  output logic                                                   protocol_err_o
);

  localparam int unsigned AW    = MEMORY_TRANSACTION_ADDR_WIDTH;
  localparam int unsigned DW    = MEMORY_TRANSACTION_DATA_WIDTH;
  localparam int unsigned BW    = DW / 8;
  localparam int unsigned IDX_W = $clog2(NUM_REQ);
  localparam int unsigned PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);

  // Lane index to one-hot lane vector
  function automatic logic [NUM_REQ-1:0] idx_to_onehot(input logic [IDX_W-1:0] idx);
    logic [NUM_REQ-1:0] oh;
    oh = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      oh[k] = (idx == IDX_W'(k));
    end
    return oh;
  endfunction

  logic [IDX_W-1:0]    fifo_q [MAX_OUTSTANDING];
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]    count_q, count_d;
  mptw_flush_status_e  status_q, status_d;
  logic                perr_q, perr_d;

  logic [IDX_W-1:0]    winner_s;
  logic                found_s;
  logic [NUM_REQ-1:0]  winner_oh_s;
  logic [IDX_W-1:0]    head_s;
  logic                flush_s, full_s, eligible_s;
  logic                push_s, pop_s, spurious_s;

`ifdef MPT_MEM_ARB_RR_EN
  logic [IDX_W-1:0]    arb_ptr_q, arb_ptr_d;
  logic [IDX_W:0]      cand_s;

  // Round-robin search starting at the arbitration pointer
  always_comb begin
    winner_s = '0;
    found_s  = 1'b0;
    cand_s   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand_s   = {1'b0, arb_ptr_q} + (IDX_W+1)'(k);
      cand_s   = (cand_s >= (IDX_W+1)'(NUM_REQ)) ? (cand_s - (IDX_W+1)'(NUM_REQ)) : cand_s;
      winner_s = (!found_s && slave_mem_req[cand_s[IDX_W-1:0]]) ? cand_s[IDX_W-1:0] : winner_s;
      found_s  = found_s | slave_mem_req[cand_s[IDX_W-1:0]];
    end
  end

  // Pointer moves just past the lane that completed a handshake
  always_comb begin
    arb_ptr_d = arb_ptr_q;
    if (push_s) begin
      arb_ptr_d = (winner_s == IDX_W'(NUM_REQ-1)) ? '0 : (winner_s + IDX_W'(1));
    end else begin
      arb_ptr_d = arb_ptr_q;
    end
  end

  // Arbitration pointer register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      arb_ptr_q <= '0;
    end else begin
      arb_ptr_q <= arb_ptr_d;
    end
  end
`else
  // Fixed priority: lowest requesting lane index wins
  always_comb begin
    winner_s = '0;
    found_s  = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      winner_s = (!found_s && slave_mem_req[k]) ? IDX_W'(k) : winner_s;
      found_s  = found_s | slave_mem_req[k];
    end
  end
`endif

  assign winner_oh_s = idx_to_onehot(winner_s);
  assign flush_s     = (stage_ctrl_flush != '0);
  assign full_s      = (count_q == CNT_W'(MAX_OUTSTANDING));
  assign eligible_s  = !full_s && !flush_s;
  assign push_s      = memory_master_mem_req && memory_master_mem_gnt;
  assign pop_s       = memory_master_mem_valid && (count_q != '0);
  assign spurious_s  = memory_master_mem_valid && (count_q == '0);
  assign head_s      = fifo_q[rd_ptr_q];

  // Request path: winner's request fields drive the master port (AND-OR mux)
  always_comb begin
    memory_master_mem_req   = eligible_s && found_s;
    memory_master_mem_addr  = '0;
    memory_master_mem_wdata = '0;
    memory_master_mem_we    = 1'b0;
    memory_master_mem_be    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      memory_master_mem_addr  = memory_master_mem_addr  | ({AW{winner_oh_s[k]}} & slave_mem_addr[k*AW +: AW]);
      memory_master_mem_wdata = memory_master_mem_wdata | ({DW{winner_oh_s[k]}} & slave_mem_wdata[k*DW +: DW]);
      memory_master_mem_we    = memory_master_mem_we    | (winner_oh_s[k] & slave_mem_we[k]);
      memory_master_mem_be    = memory_master_mem_be    | ({BW{winner_oh_s[k]}} & slave_mem_be[k*BW +: BW]);
    end
  end

  // Grant and response routing back to the lanes
  always_comb begin
    slave_mem_gnt   = push_s ? winner_oh_s : '0;
    slave_mem_valid = pop_s ? idx_to_onehot(head_s) : '0;
    slave_mem_error = (pop_s && memory_master_mem_error) ? idx_to_onehot(head_s) : '0;
    slave_mem_rdata = memory_master_mem_rdata;
  end

  // Queue pointer and occupancy next state; pointers wrap by explicit compare
  always_comb begin
    wr_ptr_d = push_s ? ((wr_ptr_q == PTR_W'(MAX_OUTSTANDING-1)) ? '0 : (wr_ptr_q + PTR_W'(1))) : wr_ptr_q;
    rd_ptr_d = pop_s  ? ((rd_ptr_q == PTR_W'(MAX_OUTSTANDING-1)) ? '0 : (rd_ptr_q + PTR_W'(1))) : rd_ptr_q;
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Outstanding queue: storage, pointers and count
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int k = 0; k < MAX_OUTSTANDING; k++) begin
        fifo_q[k] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (push_s) begin
        fifo_q[wr_ptr_q] <= winner_s;
      end
    end
  end

  // Flush status next state: tracks occupancy while a flush is requested
  always_comb begin
    status_d = MPT_FLUSHED_NONE;
    if (flush_s) begin
      status_d = (count_d != '0) ? MPT_FLUSHED_ONGOING : MPT_FLUSHED_COMPLETED;
    end else begin
      status_d = MPT_FLUSHED_NONE;
    end
    perr_d = spurious_s;
  end

  // Flush status state and protocol error pulse registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      status_q <= MPT_FLUSHED_NONE;
      perr_q   <= 1'b0;
    end else begin
      status_q <= status_d;
      perr_q   <= perr_d;
    end
  end

  // Status and error outputs come straight from registers
  always_comb begin
    stage_status_flushed = status_q;
    protocol_err_o       = perr_q;
  end

endmodule
